clk_div_cfg_ctrl: RTL

Configuration sequencer for the UART receive clock divider. Accepts prescale requests (32/16/8/4) from the register file, validates and decodes each into a divider ratio, and applies the new ratio only at a divided-clock period boundary. The divider is held disabled for a short settle window around every ratio change. It sits between the register file and the integer clock divider, and is the only driver of the divider's ratio and enable inputs.

---
 rtl/clk_div_cfg_pkg.sv | 28 ++
 rtl/clk_div_cfg_ctrl_decode.sv | 30 +++
 rtl/clk_div_cfg_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clk_div_cfg_pkg.sv
// ============================================================================
// clk_div_cfg_pkg : prescale codes, divider ratios and FSM states   (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package clk_div_cfg_pkg;

   localparam logic [5:0] PRESC_32 = 6'b100000;
   localparam logic [5:0] PRESC_16 = 6'b010000;
   localparam logic [5:0] PRESC_8  = 6'b001000;
   localparam logic [5:0] PRESC_4  = 6'b000100;

   localparam logic [7:0] RATIO_1 = 8'd1;
   localparam logic [7:0] RATIO_2 = 8'd2;
   localparam logic [7:0] RATIO_4 = 8'd4;
   localparam logic [7:0] RATIO_8 = 8'd8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      APPLY     = 2'd2,
      SETTLE    = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_cfg_ctrl_decode.sv
// ============================================================================
// prescale_ratio_decode : one-hot prescale code to divider ratio   (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prescale_ratio_decode
   import clk_div_cfg_pkg::*;
(
   input  logic [5:0] i_code,
   output logic [7:0] o_ratio,
   output logic       o_valid
);

   // Anything but the four legal one-hot codes falls back to ratio 1, invalid.
   always_comb begin
      o_ratio = RATIO_1;
      o_valid = 1'b0;
      case (i_code)
         PRESC_32: begin o_ratio = RATIO_1; o_valid = 1'b1; end
         PRESC_16: begin o_ratio = RATIO_2; o_valid = 1'b1; end
         PRESC_8:  begin o_ratio = RATIO_4; o_valid = 1'b1; end
         PRESC_4:  begin o_ratio = RATIO_8; o_valid = 1'b1; end
         default:  ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/clk_div_cfg_ctrl.sv
// ============================================================================
// clk_div_cfg_ctrl : UART rx divider ratio/enable sequencer        (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_cfg_ctrl
   import clk_div_cfg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 255
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       ctrl_en,
   input  logic [5:0] cfg_prescale,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic       div_period_end,
   output logic [7:0] div_ratio,
   output logic       div_en,
   output logic       busy,
   output logic       upd_done,
   output logic       cfg_err
);

   localparam logic [7:0] c_TIMEOUT     = 8'(TIMEOUT);
   localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e     r_state;
   state_e     w_state_nxt;
   logic [7:0] r_shadow;
   logic [7:0] r_div_ratio;
   logic [7:0] r_tcnt;
   logic [3:0] r_scnt;
   logic       r_ctrl_en_q;
   logic       r_upd_done;
   logic       r_cfg_err;
   logic [7:0] w_dec_ratio;
   logic       w_dec_valid;
   logic       w_new_req;

   prescale_ratio_decode u_decode (
      .i_code  (cfg_prescale),
      .o_ratio (w_dec_ratio),
      .o_valid (w_dec_valid)
   );

   // A request equal to the ratio already in force completes without a disable window.
   assign w_new_req = cfg_valid && w_dec_valid && (w_dec_ratio != r_div_ratio);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_new_req) begin
               w_state_nxt = r_ctrl_en_q ? WAIT_EDGE : APPLY;
            end
         end
         WAIT_EDGE: begin
            if (div_period_end || (r_tcnt == c_TIMEOUT) || !r_ctrl_en_q) begin
               w_state_nxt = APPLY;
            end
         end
         APPLY: begin
            w_state_nxt = SETTLE;
         end
         SETTLE: begin
            if (r_scnt == c_SETTLE_LAST) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      cfg_ready = (r_state == IDLE);
      busy      = (r_state != IDLE);
      div_en    = r_ctrl_en_q && (r_state != APPLY) && (r_state != SETTLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shadow    <= RATIO_1;
         r_div_ratio <= RATIO_1;
         r_tcnt      <= 8'd0;
         r_scnt      <= 4'd0;
         r_ctrl_en_q <= 1'b0;
         r_upd_done  <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_ctrl_en_q <= ctrl_en;
         r_upd_done  <= 1'b0;
         r_cfg_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               // Holding the timeout counter at zero here clears it on WAIT_EDGE entry.
               r_tcnt <= 8'd0;
               if (cfg_valid) begin
                  if (!w_dec_valid) begin
                     r_cfg_err <= 1'b1;
                  end else if (w_dec_ratio == r_div_ratio) begin
                     r_upd_done <= 1'b1;
                  end else begin
                     r_shadow <= w_dec_ratio;
                  end
               end
            end
            WAIT_EDGE: begin
               r_tcnt <= r_tcnt + 8'd1;
            end
            APPLY: begin
               r_div_ratio <= r_shadow;
               r_scnt      <= 4'd0;
            end
            SETTLE: begin
               r_scnt <= r_scnt + 4'd1;
               if (r_scnt == c_SETTLE_LAST) begin
                  r_upd_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_ratio = r_div_ratio;
   assign upd_done  = r_upd_done;
   assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire
